pwm_seq_ctrl: RTL
=================

// Module: pwm_seq_ctrl
// PURPOSE
//  Sequencer that sits between a host and one timer_pwm instance.
//  Holds a table of PWM profiles; each profile is {max_count, pwm_count, stop_count}.
//  For each profile it writes the three timer registers (addr 0/1/2), pulses start,
//  and waits for timer end. It then moves to the next profile, or finishes/loops.
// PARAMETERS
//  DEPTH    8   number of profile entries in the table (power of 2, >=2)
//  IDX_W    3   index width, equals log2(DEPTH)
//  TIMEOUT  0   max WAIT_END cycles before error; 0 disables the watchdog
// PORTS
//  iCLK          in   1      clock, all state changes on posedge
//  iRST          in   1      asynchronous reset, active-high
//  iCfgWe        in   1      table write strobe, ignored while oBusy=1
//  iCfgIdx       in   IDX_W  table entry being written
//  iCfgFld       in   2      field select: 0=max, 1=pwm, 2=stop; 3 is ignored
//  iCfgWdata     in   16     table write data
//  iLen          in   IDX_W+1  number of entries to run, sampled on iGo
//  iGo           in   1      start the sequence, sampled only in IDLE
//  iAbort        in   1      abort the sequence, highest priority
//  iTimer_End    in   1      timer_pwm oTimer_End
//  oAddr         out  2      timer_pwm iAddr
//  oWe           out  1      timer_pwm iWe
//  oWdata        out  16     timer_pwm iWdata
//  oStart        out  1      timer_pwm iStart
//  oBusy         out  1      high in every state except IDLE
//  oIdx          out  IDX_W  entry currently running
//  oDone         out  1      1-cycle pulse when the sequence completes
//  oErr          out  1      sticky watchdog error; cleared by iGo or reset
// BEHAVIOUR
//  - Reset (async): state=IDLE; all outputs 0; table contents 0; end-edge flop 0.
//  - Outputs are decoded from the registered state (Moore).
//    oAddr/oWdata are 0 when oWe=0.
//  - States: IDLE, WR_MAX, WR_PWM, WR_STOP, START, WAIT_END, DONE.
//  - IDLE: iGo=1 at edge k:
//    - iLen=0  -> DONE at k+1 (oDone pulse, no timer writes).
//    - iLen>0  -> latch len, idx=0, clear oErr, go to WR_MAX.
//    - iLen>DEPTH is clamped to DEPTH.
//  - Per-entry cycle sequence (cycle numbers count from go edge k):
//    - WR_MAX    k+1  oAddr=0  oWe=1  oWdata=max[idx]
//    - WR_PWM    k+2  oAddr=1  oWe=1  oWdata=pwm[idx]
//    - WR_STOP   k+3  oAddr=2  oWe=1  oWdata=stop[idx]
//    - START     k+4  oStart=1 for exactly one cycle
//    - WAIT_END  from k+5
//  - WAIT_END advances only on a rising edge of iTimer_End
//    (iTimer_End=1 and previous sample=0). A level already high on entry is ignored.
//    - On the edge: if idx==len-1 go to DONE; else idx+1 and go to WR_MAX.
//    - There are no idle cycles between entries.
//  - DONE: oDone=1 for one cycle, then IDLE.
//  - Watchdog (TIMEOUT>0): counter cleared on entering WAIT_END.
//    At count==TIMEOUT with no edge: set oErr=1, go to IDLE, no oDone.
//  - iAbort=1: any state -> IDLE on the next edge.
//    - Outputs drop to 0 that same cycle; no oDone; oErr unchanged.
//    - iAbort has priority over iGo and over a simultaneous end edge.
//  - iGo while oBusy=1: ignored. iCfgWe while oBusy=1: ignored, table unchanged.
//  - Simultaneous iCfgWe and iGo in IDLE: the write commits; the sequence reads
//    the table starting one cycle later, so it sees the new value.
//  - Async reset mid-sequence: immediate return to IDLE, outputs 0.
//    The timer itself is not told to stop.
// CONFIGURATION
//  - Macro PWM_SEQ_LOOP_EN:
//    - Defined: after the last entry's end edge, idx wraps to 0 and WR_MAX
//      follows directly. oDone pulses once per completed pass.
//      The sequence runs until iAbort or a watchdog error.
//    - Undefined: the sequence runs once, then DONE -> IDLE.
// TESTING
//  1. Reset: iRST high mid-WAIT_END -> all outputs 0 and oBusy=0 immediately.
//  2. Table e0={15,5,0}, iLen=1, iGo -> oWe writes 0:15, 1:5, 2:0 on consecutive
//     cycles. oStart 1 cycle. iTimer_End rise -> oDone one cycle later, oBusy=0.
//  3. Table e0={15,5,0}, e1={10,6,2}, iLen=2; iTimer_End held high from the prior
//     run -> no advance until it falls and rises. Then e1 writes 0:10, 1:6, 2:2,
//     and oIdx=1.
//  4. TIMEOUT=20, iTimer_End never rises -> oErr=1 and IDLE 20 cycles after
//     WAIT_END entry. A following iGo clears oErr.
//  5. iAbort asserted in WR_PWM -> IDLE next cycle, no addr-2 write, no oDone.
//     iGo and iCfgWe while busy leave the table and state unchanged.
//  6. PWM_SEQ_LOOP_EN defined, iLen=2 -> idx 0,1,0,1; oDone after each pass;
//     iAbort stops the sequence.

Source files
------------

// File: rtl/pwm_seq_ctrl_if.sv
// Host/timer bus of the PWM profile sequencer.
// master: host side (drives table writes, go/abort, timer end), slave: sequencer.
interface pwm_seq_ctrl_if #(
    parameter int unsigned IDX_W = 3
);
    logic             iCfgWe;
    logic [IDX_W-1:0] iCfgIdx;
    logic [1:0]       iCfgFld;
    logic [15:0]      iCfgWdata;
    logic [IDX_W:0]   iLen;
    logic             iGo;
    logic             iAbort;
    logic             iTimer_End;
    logic [1:0]       oAddr;
    logic             oWe;
    logic [15:0]      oWdata;
    logic             oStart;
    logic             oBusy;
    logic [IDX_W-1:0] oIdx;
    logic             oDone;
    logic             oErr;

    modport master (
        output iCfgWe, iCfgIdx, iCfgFld, iCfgWdata, iLen, iGo, iAbort, iTimer_End,
        input  oAddr, oWe, oWdata, oStart, oBusy, oIdx, oDone, oErr
    );

    modport slave (
        input  iCfgWe, iCfgIdx, iCfgFld, iCfgWdata, iLen, iGo, iAbort, iTimer_End,
        output oAddr, oWe, oWdata, oStart, oBusy, oIdx, oDone, oErr
    );
endinterface

// File: rtl/pwm_seq_ctrl.sv
// PWM profile sequencer: walks a table of {max, pwm, stop} profiles, programs a
// timer_pwm with each one, pulses start and waits for the timer end edge.
// Optional build macro PWM_SEQ_LOOP_EN: wrap to entry 0 after the last entry
// instead of finishing (oDone then pulses once per completed pass).
module pwm_seq_ctrl #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned IDX_W   = 3,
    parameter int unsigned TIMEOUT = 0
) (
    input  logic           iCLK,
    input  logic           iRST,
    pwm_seq_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_MAX,
        S_WR_PWM,
        S_WR_STOP,
        S_START,
        S_WAIT_END,
        S_DONE
    } state_t;

    localparam logic [IDX_W:0] LEN_MAX = (IDX_W+1)'(DEPTH);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W:0]   len_q, len_d;
    logic [IDX_W:0]   len_in;
    logic             err_q, err_d;
    logic [31:0]      wd_q, wd_d;
    logic             pass_q, pass_d;
    logic             end_q;
    logic             end_rise;
    logic             last_entry;
    logic             timeout_hit;

    logic [15:0] max_tbl  [DEPTH];
    logic [15:0] pwm_tbl  [DEPTH];
    logic [15:0] stop_tbl [DEPTH];

    assign end_rise    = bus.iTimer_End & ~end_q;
    assign last_entry  = ({1'b0, idx_q} == (len_q - 1'b1));
    assign timeout_hit = (TIMEOUT != 0) && ((wd_q + 32'd1) == TIMEOUT);
    assign len_in      = (bus.iLen > LEN_MAX) ? LEN_MAX : bus.iLen;

    // Profile table: host writes land only while the sequencer is idle.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                max_tbl[i]  <= '0;
                pwm_tbl[i]  <= '0;
                stop_tbl[i] <= '0;
            end
        end else if (bus.iCfgWe && (state_q == S_IDLE)) begin
            case (bus.iCfgFld)
                2'd0:    max_tbl[bus.iCfgIdx]  <= bus.iCfgWdata;
                2'd1:    pwm_tbl[bus.iCfgIdx]  <= bus.iCfgWdata;
                2'd2:    stop_tbl[bus.iCfgIdx] <= bus.iCfgWdata;
                default: ;
            endcase
        end
    end

    // State register plus the sequencing datapath it owns.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
            wd_q    <= '0;
            pass_q  <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
            pass_q  <= pass_d;
            end_q   <= bus.iTimer_End;
        end
    end

    // Next-state and datapath update; abort overrides every other condition.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        err_d   = err_q;
        wd_d    = wd_q;
        pass_d  = 1'b0;
        if (bus.iAbort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.iGo) begin
                        err_d = 1'b0;
                        if (bus.iLen == '0) begin
                            state_d = S_DONE;
                        end else begin
                            len_d   = len_in;
                            idx_d   = '0;
                            state_d = S_WR_MAX;
                        end
                    end
                end
                S_WR_MAX:  state_d = S_WR_PWM;
                S_WR_PWM:  state_d = S_WR_STOP;
                S_WR_STOP: state_d = S_START;
                S_START: begin
                    wd_d    = '0;
                    state_d = S_WAIT_END;
                end
                S_WAIT_END: begin
                    if (end_rise) begin
                        if (last_entry) begin
`ifdef PWM_SEQ_LOOP_EN
                            // Loop mode: the pass-complete pulse is a flop because
                            // WR_MAX itself cannot encode it.
                            idx_d   = '0;
                            pass_d  = 1'b1;
                            state_d = S_WR_MAX;
`else
                            state_d = S_DONE;
`endif
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = S_WR_MAX;
                        end
                    end else if (timeout_hit) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        wd_d = wd_q + 32'd1;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Moore output decode from the registered state.
    always_comb begin
        bus.oAddr  = '0;
        bus.oWe    = 1'b0;
        bus.oWdata = '0;
        bus.oStart = 1'b0;
        bus.oBusy  = (state_q != S_IDLE);
        bus.oIdx   = (state_q != S_IDLE) ? idx_q : '0;
        bus.oDone  = (state_q == S_DONE) | pass_q;
        bus.oErr   = err_q;
        case (state_q)
            S_WR_MAX: begin
                bus.oAddr  = 2'd0;
                bus.oWe    = 1'b1;
                bus.oWdata = max_tbl[idx_q];
            end
            S_WR_PWM: begin
                bus.oAddr  = 2'd1;
                bus.oWe    = 1'b1;
                bus.oWdata = pwm_tbl[idx_q];
            end
            S_WR_STOP: begin
                bus.oAddr  = 2'd2;
                bus.oWe    = 1'b1;
                bus.oWdata = stop_tbl[idx_q];
            end
            S_START: bus.oStart = 1'b1;
            default: ;
        endcase
    end

endmodule
